bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between the credit/price source, the converter and the display.
interface bin2bcd_seq_if #(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [3:0]       Dig1;
   logic [3:0]       Dig2;
   logic [3:0]       Dig3;
   logic [3:0]       Dig4;

   modport master (
      output start, bin,
      input  busy, done, ovf, Dig1, Dig2, Dig3, Dig4
   );

   modport slave (
      input  start, bin,
      output busy, done, ovf, Dig1, Dig2, Dig3, Dig4
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Shift-add-3 binary to 4-digit BCD, one bit per clock; done/digits 15 cycles after start (BIN_W=14).
// No queuing: start is ignored while busy. Leading-zero blanking under LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
   parameter int         BIN_W      = 14,
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input logic          clk,
   input logic          clr,
   bin2bcd_seq_if.slave bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_accept;
   logic [BIN_W-1:0] r_sr;
   logic [15:0]      r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf_n;
   logic [15:0]      r_dig;
   logic             r_ovf;
   logic             r_done;
   logic [15:0]      w_adj;
   logic [15:0]      w_sat;
   logic [15:0]      w_res;

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_next_state = SHIFT;
               w_accept     = 1'b1;
            end else begin
               w_next_state = IDLE;
            end
         end
         SHIFT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = DONE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Out-of-range inputs saturate; the scratch may hold garbage nibbles then.
   assign w_sat = r_ovf_n ? 16'h9999 : r_bcd;

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      w_res = w_sat;
      if (w_sat[15:12] == 4'd0) begin
         w_res[15:12] = BLANK_CODE;
         if (w_sat[11:8] == 4'd0) begin
            w_res[11:8] = BLANK_CODE;
            if (w_sat[7:4] == 4'd0) begin
               w_res[7:4] = BLANK_CODE;
            end
         end
      end
   end
`else
   logic w_unused_blank;
   assign w_unused_blank = ^BLANK_CODE;
   assign w_res          = w_sat;
`endif

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_sr    <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_ovf_n <= 1'b0;
         r_dig   <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_sr    <= bus.bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_ovf_n <= (32'(bus.bin) > 32'd9999);
         end else if (r_state == SHIFT) begin
            r_bcd <= {w_adj[14:0], r_sr[BIN_W-1]};
            r_sr  <= r_sr << 1;
            r_cnt <= r_cnt - 1'b1;
         end
         // Result registers read the finished scratch even if a new start reloads it on this edge.
         if (r_state == DONE) begin
            r_dig  <= w_res;
            r_ovf  <= r_ovf_n;
            r_done <= 1'b1;
         end
      end
   end

   assign bus.busy = (r_state == SHIFT);
   assign bus.done = r_done;
   assign bus.ovf  = r_ovf;
   assign bus.Dig1 = r_dig[15:12];
   assign bus.Dig2 = r_dig[11:8];
   assign bus.Dig3 = r_dig[7:4];
   assign bus.Dig4 = r_dig[3:0];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: constant vector table, corner sequences and a random run against an arithmetic model.
module tb_bin2bcd_seq;
   logic clk;
   logic clr;
   int   n_checks;
   int   n_errors;

   bin2bcd_seq_if #(.BIN_W(14)) bus ();

   bin2bcd_seq #(.BIN_W(14), .BLANK_CODE(4'hF)) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          bin;
      logic [15:0] dig;
      logic        ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] blank(input logic [15:0] p);
      logic [15:0] r;
      r = p;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 3; i >= 1; i--) begin
         if (r[4*i +: 4] != 4'd0) break;
         r[4*i +: 4] = 4'hF;
      end
`endif
      return r;
   endfunction

   function automatic logic [15:0] model(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return blank({4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)});
   endfunction

   function automatic logic [15:0] digits();
      return {bus.Dig1, bus.Dig2, bus.Dig3, bus.Dig4};
   endfunction

   // Called just after a negedge; returns at the negedge after the accepting edge.
   task automatic launch(input int v);
      bus.start = 1'b1;
      bus.bin   = 14'(v);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic check_conv(input string name, input logic [15:0] exp_dig,
                             input logic exp_ovf, input int exp_lat);
      logic [15:0] d0;
      logic        o0;
      bit          stable;
      bit          busy_ok;
      int          cyc;
      d0      = digits();
      o0      = bus.ovf;
      stable  = 1'b1;
      busy_ok = 1'b1;
      cyc     = 0;
      while (!bus.done && cyc < 40) begin
         if (digits() !== d0 || bus.ovf !== o0) stable = 1'b0;
         if (cyc < exp_lat - 1 && bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({name, " digits"}, 32'(digits()), 32'(exp_dig));
      chk({name, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
      chk({name, " hold"}, 32'(stable), 32'd1);
      chk({name, " busy_during"}, 32'(busy_ok), 32'd1);
      chk({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[10];
      int   v;
      bit   no_done;

      n_checks = 0;
      n_errors = 0;
      vecs[0] = '{1234,  16'h1234, 1'b0};
      vecs[1] = '{0,     16'h0000, 1'b0};
      vecs[2] = '{9999,  16'h9999, 1'b0};
      vecs[3] = '{10000, 16'h9999, 1'b1};
      vecs[4] = '{16383, 16'h9999, 1'b1};
      vecs[5] = '{7,     16'h0007, 1'b0};
      vecs[6] = '{90,    16'h0090, 1'b0};
      vecs[7] = '{1000,  16'h1000, 1'b0};
      vecs[8] = '{305,   16'h0305, 1'b0};
      vecs[9] = '{5678,  16'h5678, 1'b0};

      clr       = 1'b0;
      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset ovf", 32'(bus.ovf), 32'd0);
      chk("reset digits", 32'(digits()), 32'h0000);
      clr = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         launch(vecs[i].bin);
         check_conv($sformatf("vec%0d", i), blank(vecs[i].dig), vecs[i].ovf, 15);
         @(negedge clk);
         chk($sformatf("vec%0d done_width", i), 32'(bus.done), 32'd0);
      end

      // Start while busy is ignored; bin changes right after capture.
      launch(42);
      bus.bin = 14'd777;
      repeat (5) @(negedge clk);
      chk("ignore busy_at_start2", 32'(bus.busy), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_conv("ignore", blank(16'h0042), 1'b0, 9);
      @(negedge clk);
      chk("ignore busy_after", 32'(bus.busy), 32'd0);
      chk("ignore no_second_done", 32'(bus.done), 32'd0);

      // Back-to-back: second start issued in the cycle done is high.
      launch(1234);
      check_conv("b2b_first", blank(16'h1234), 1'b0, 15);
      launch(500);
      check_conv("b2b_second", blank(16'h0500), 1'b0, 15);
      @(negedge clk);

      // Abort mid-conversion.
      launch(8888);
      repeat (5) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort digits", 32'(digits()), 32'h0000);
      chk("abort ovf", 32'(bus.ovf), 32'd0);
      no_done = 1'b1;
      repeat (20) begin
         if (bus.done !== 1'b0) no_done = 1'b0;
         @(negedge clk);
      end
      chk("abort no_done", 32'(no_done), 32'd1);
      launch(7);
      check_conv("after_abort", blank(16'h0007), 1'b0, 15);
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         v = (i % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
         launch(v);
         check_conv($sformatf("rand%0d(%0d)", i, v), model(v), (v > 9999), 15);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
